shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencing controller that drives the model machine's combinational bus shifter. It accepts a rotate command (direction, count 0–7, 8-bit operand) over a start/done handshake. It then steps the shifter one bit per clock by driving its select lines, and feeds each result back as the next operand. When the sequence ends it presents the final word and the carry flag.

## Interface
Parameters:
- None; datapath width is fixed at 8 bits (package constant).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command request; sampled only in IDLE
- dir  in  1  0 = rotate left, 1 = rotate right; captured with start
- cnt  in  3  number of single-bit rotates (0–7); captured with start
- din  in  8  operand; captured with start
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse; dout/cf valid
- dout  out  8  result; held until next accepted start
- cf  out  1  carry: last bit rotated out; 0 for cnt = 0
- fbus  out  1  shifter pass-through select
- flbus  out  1  shifter rotate-left select
- frbus  out  1  shifter rotate-right select
- sh_a  out  8  operand driven to shifter
- sh_w  in  8  shifter result
- sh_cf  in  1  shifter carry

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start = 1. Captures din → work register, dir, cnt; remaining = max(cnt,1).
- SHIFT:
  - sh_a = work register.
  - Selects: cnt = 0 → {fbus,flbus,frbus} = 100; dir = 0 → 010; dir = 1 → 001.
  - Each cycle: work ← sh_w, carry ← sh_cf, remaining ← remaining − 1.
  - When remaining = 1, transition to DONE.
- DONE:
  - dout ← work, cf ← carry; done = 1 for exactly one cycle.
  - → IDLE unconditionally.
- Outside SHIFT, selects are 000, so the shifter releases the bus (high-Z). sh_a = work register.
- Exactly one select is high at any time in SHIFT; never two.
- start during SHIFT or DONE is ignored (not queued).
- Reset (any state, including mid-SHIFT) → IDLE, work = 0, dout = 0x00, cf = 0, busy = 0, done = 0, selects = 000, sh_a = 0x00. The partial result is discarded.
- The carry reflects only the final step. cnt = 0 yields cf = 0 (the shifter's pass-through carry).

## Timing
- Start accepted at edge T0. SHIFT occupies edges T1..Tn, where n = max(cnt,1). DONE is visible in the cycle after Tn, and done is high for that cycle.
- Latency from accepted start to done: max(cnt,1) + 1 cycles. Earliest next start is in the cycle after done.
- busy is high during SHIFT and DONE.
- The shifter is purely combinational. sh_w and sh_cf are sampled in the same cycle the selects are driven; there is no extra wait state.

## Configuration
- SHIFT_SEQ_CTRL_ZFLAG_EN defined:
  - Adds output zf (1 bit), updated with dout in DONE: zf = (result == 0x00).
  - Reset value of zf is 0.
- Undefined: the zf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package shift_pkg holds:
  - DATA_W = 8
  - state enum {IDLE, SHIFT, DONE}
  - select encodings SEL_PASS = 3'b100, SEL_ROL = 3'b010, SEL_ROR = 3'b001, SEL_NONE = 3'b000
- No sub-module. The bus shifter is instantiated beside this block at the datapath level and connected through the sh_*/select ports. The bench instantiates both.

## Test plan
- din = 0x81, dir = 0, cnt = 1 → one SHIFT cycle with select 010; done 2 cycles after start; dout = 0x03, cf = 1.
- din = 0x81, dir = 1, cnt = 1 → select 001; dout = 0xC0, cf = 1.
- din = 0x96, dir = 0, cnt = 4 → intermediates 0x2D, 0x5A, 0xB4, 0x69; done 5 cycles after start; dout = 0x69, cf = 1.
- din = 0x5A, cnt = 0 → fbus high for exactly one cycle; dout = 0x5A, cf = 0; selects 000 before and after.
- din = 0x96, dir = 1, cnt = 7, start pulsed again mid-SHIFT with din = 0xFF → second start ignored; dout = 0x2D, cf = 0. Repeat with rst asserted after 3 SHIFT cycles → next cycle IDLE, dout = 0x00, busy = 0, selects 000, no done pulse.
- With SHIFT_SEQ_CTRL_ZFLAG_EN: din = 0x00, dir = 0, cnt = 3 → dout = 0x00, zf = 1, cf = 0. Then din = 0x01, cnt = 1 → zf = 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the bus-shifter sequencing controller: datapath width,
// FSM state encoding and the shifter select-line encodings.
package shift_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Select order on the bus is {fbus, flbus, frbus}.
    localparam logic [2:0] SEL_PASS = 3'b100;
    localparam logic [2:0] SEL_ROL  = 3'b010;
    localparam logic [2:0] SEL_ROR  = 3'b001;
    localparam logic [2:0] SEL_NONE = 3'b000;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Steps an external combinational bus shifter one bit per clock to perform a
// multi-bit rotate. Optional zero flag output: define SHIFT_SEQ_CTRL_ZFLAG_EN.
module shift_seq_ctrl
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [2:0]        cnt,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              cf,
`ifdef SHIFT_SEQ_CTRL_ZFLAG_EN
    output logic              zf,
`endif
    output logic              fbus,
    output logic              flbus,
    output logic              frbus,
    output logic [DATA_W-1:0] sh_a,
    input  logic [DATA_W-1:0] sh_w,
    input  logic              sh_cf
);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_work;
    logic                r_dir;
    logic [2:0]          r_cnt;
    logic [2:0]          r_rem;
    logic [DATA_W-1:0]   r_dout;
    logic                r_cf;
    logic [2:0]          w_sel;
    logic                w_last_step;

    assign w_last_step = (r_state == SHIFT) && (r_rem == 3'd1);

    always_comb begin
        w_state_next = r_state;
        w_sel        = SEL_NONE;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == 3'd0) begin
                    w_sel = SEL_PASS;
                end else if (r_dir) begin
                    w_sel = SEL_ROR;
                end else begin
                    w_sel = SEL_ROL;
                end
                if (r_rem == 3'd1) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The result is captured on the final shift edge so that dout/cf are
    // already valid during the DONE cycle in which done is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= 3'd0;
            r_rem   <= 3'd0;
            r_dout  <= '0;
            r_cf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && start) begin
                r_work <= din;
                r_dir  <= dir;
                r_cnt  <= cnt;
                r_rem  <= (cnt == 3'd0) ? 3'd1 : cnt;
            end
            if (r_state == SHIFT) begin
                r_work <= sh_w;
                r_rem  <= r_rem - 3'd1;
            end
            if (w_last_step) begin
                r_dout <= sh_w;
                r_cf   <= sh_cf;
            end
        end
    end

`ifdef SHIFT_SEQ_CTRL_ZFLAG_EN
    logic r_zf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b0;
        end else if (w_last_step) begin
            r_zf <= (sh_w == '0);
        end
    end

    assign zf = r_zf;
`endif

    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE);
    assign dout  = r_dout;
    assign cf    = r_cf;
    assign sh_a  = r_work;
    assign fbus  = w_sel[2];
    assign flbus = w_sel[1];
    assign frbus = w_sel[0];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl together with a behavioural bus shifter; table of
// rotate commands plus hand-written abort/reset sequences.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic [2:0] cnt;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       cf;
    logic       fbus;
    logic       flbus;
    logic       frbus;
    logic [7:0] sh_a;
    logic [7:0] sh_w;
    logic       sh_cf;
`ifdef SHIFT_SEQ_CTRL_ZFLAG_EN
    logic       zf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .cnt   (cnt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .cf    (cf),
`ifdef SHIFT_SEQ_CTRL_ZFLAG_EN
        .zf    (zf),
`endif
        .fbus  (fbus),
        .flbus (flbus),
        .frbus (frbus),
        .sh_a  (sh_a),
        .sh_w  (sh_w),
        .sh_cf (sh_cf)
    );

    // Behavioural combinational bus shifter; a released bus reads as zero.
    always_comb begin
        sh_w  = 8'h00;
        sh_cf = 1'b0;
        case ({fbus, flbus, frbus})
            3'b100: begin sh_w = sh_a;                  sh_cf = 1'b0;     end
            3'b010: begin sh_w = {sh_a[6:0], sh_a[7]};  sh_cf = sh_a[7];  end
            3'b001: begin sh_w = {sh_a[0], sh_a[7:1]};  sh_cf = sh_a[0];  end
            default: begin sh_w = 8'h00;                sh_cf = 1'b0;     end
        endcase
    end

    typedef struct {
        logic [7:0] din;
        logic       dir;
        logic [2:0] cnt;
        logic [7:0] exp_dout;
        logic       exp_cf;
        logic       exp_zf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] rot(input logic [7:0] v, input logic d, input int k);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < k; i++) begin
            r = d ? {r[0], r[7:1]} : {r[6:0], r[7]};
        end
        return r;
    endfunction

    task automatic run_cmd(input vec_t v, input int idx);
        int         lat;
        int         n;
        logic [2:0] exp_sel;
        n       = (v.cnt == 3'd0) ? 1 : int'(v.cnt);
        exp_sel = (v.cnt == 3'd0) ? 3'b100 : (v.dir ? 3'b001 : 3'b010);
        @(negedge clk);
        check("idle_sel", int'({fbus, flbus, frbus}), 0);
        din   = v.din;
        dir   = v.dir;
        cnt   = v.cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat <= 20) begin
            check("shift_sel", int'({fbus, flbus, frbus}), int'(exp_sel));
            check("shift_sh_a", int'(sh_a),
                  int'(rot(v.din, v.dir, (v.cnt == 3'd0) ? 0 : lat - 1)));
            @(negedge clk);
            lat++;
        end
        check("latency", lat, n + 1);
        check("dout", int'(dout), int'(v.exp_dout));
        check("cf", int'(cf), int'(v.exp_cf));
        check("busy_done", int'(busy), 1);
        check("done_sel", int'({fbus, flbus, frbus}), 0);
`ifdef SHIFT_SEQ_CTRL_ZFLAG_EN
        check("zf", int'(zf), int'(v.exp_zf));
`endif
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("dout_hold", int'(dout), int'(v.exp_dout));
        $display("vec %0d din=%02h dir=%0d cnt=%0d -> dout=%02h cf=%0d lat=%0d",
                 idx, v.din, v.dir, v.cnt, dout, cf, lat);
    endtask

    initial begin
        int   lat;
        logic seen_done;
        vecs[0] = '{8'h81, 1'b0, 3'd1, 8'h03, 1'b1, 1'b0};
        vecs[1] = '{8'h81, 1'b1, 3'd1, 8'hC0, 1'b1, 1'b0};
        vecs[2] = '{8'h96, 1'b0, 3'd4, 8'h69, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 3'd0, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'h96, 1'b1, 3'd7, 8'h2D, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 3'd1, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{8'h5A, 1'b1, 3'd0, 8'h5A, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        cnt   = 3'd0;
        din   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_cf", int'(cf), 0);
        check("rst_sel", int'({fbus, flbus, frbus}), 0);
        check("rst_sh_a", int'(sh_a), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], i);
        end

        // Second start in the middle of SHIFT must be ignored.
        @(negedge clk);
        din = 8'h96; dir = 1'b1; cnt = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (2) begin @(negedge clk); lat++; end
        din = 8'hFF; dir = 1'b0; cnt = 3'd2; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat <= 20) begin @(negedge clk); lat++; end
        check("ign_latency", lat, 8);
        check("ign_dout", int'(dout), 8'h2D);
        check("ign_cf", int'(cf), 0);
        $display("ignored-start seq: dout=%02h cf=%0d lat=%0d", dout, cf, lat);

        // Reset after three SHIFT cycles discards the partial result.
        @(negedge clk);
        din = 8'h96; dir = 1'b1; cnt = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_sel", int'({fbus, flbus, frbus}), 0);
        check("mid_rst_sh_a", int'(sh_a), 0);
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("mid_rst_no_done", int'(seen_done), 0);
        $display("mid-shift reset seq: busy=%0d dout=%02h", busy, dout);

        run_cmd(vecs[2], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
